// File: rtl/wl_tdm_serializer_pkg.sv
// rtl/wl_tdm_serializer_pkg.sv - shared constants and state type for the WL TDM serializer
package wl_tdm_serializer_pkg;

  localparam int NUM_INPUTS     = 64;
  localparam int WL_GROUP_WIDTH = 8;
  localparam int WL_GROUPS      = NUM_INPUTS / WL_GROUP_WIDTH;
  localparam int WL_HOLD_W      = 4;
  localparam int WL_FIFO_DEPTH  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } wl_tdm_state_t;

endpackage

// File: rtl/wl_tdm_serializer_if.sv
// rtl/wl_tdm_serializer_if.sv - frame valid/ready handshake between cim_array_ctrl and the serializer
interface wl_tdm_serializer_if
  import wl_tdm_serializer_pkg::*;
#(
  parameter int P_NUM_INPUTS = NUM_INPUTS
) ();

  logic [P_NUM_INPUTS-1:0] wl_bitmap_in;
  logic                    wl_valid_in;
  logic                    wl_ready_out;

  modport master (output wl_bitmap_in, output wl_valid_in, input wl_ready_out);
  modport slave  (input wl_bitmap_in, input wl_valid_in, output wl_ready_out);

endinterface

// File: rtl/wl_tdm_serializer_group_next_finder.sv
// rtl/wl_tdm_serializer_group_next_finder.sv - picks the first and the next group to send from a non-zero mask
module wl_group_next_finder
  import wl_tdm_serializer_pkg::*;
#(
  parameter  int GROUPS = WL_GROUPS,
  localparam int IDX_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic [GROUPS-1:0] nz_mask,
  input  logic [IDX_W-1:0]  cur_idx,
  input  logic              skip,
  output logic [IDX_W-1:0]  next_idx,
  output logic              found,
  output logic [IDX_W-1:0]  first_idx
);

  // Scan downwards so the lowest qualifying group is the last one written.
  // Without skip every group qualifies, so first is 0 and next is cur+1.
  always_comb begin
    next_idx  = cur_idx;
    found     = 1'b0;
    first_idx = '0;
    for (int i = GROUPS - 1; i >= 0; i--) begin
      if ((i > int'(cur_idx)) && (nz_mask[i] || !skip)) begin
        next_idx = IDX_W'(i);
        found    = 1'b1;
      end
      if (skip && nz_mask[i]) begin
        first_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wl_tdm_serializer.sv
// rtl/wl_tdm_serializer.sv - frame FIFO plus group-by-group WL serializer with hold and zero-skip
module wl_tdm_serializer
  import wl_tdm_serializer_pkg::*;
#(
  parameter  int P_NUM_INPUTS = NUM_INPUTS,
  parameter  int P_GROUP_W    = WL_GROUP_WIDTH,
  parameter  int P_HOLD_W     = WL_HOLD_W,
  parameter  int P_FIFO_DEPTH = WL_FIFO_DEPTH,
  localparam int GROUPS       = P_NUM_INPUTS / P_GROUP_W,
  localparam int IDX_W        = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int CNT_W        = $clog2(GROUPS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  wl_tdm_serializer_if.slave      frame_if,
  input  logic [P_HOLD_W-1:0]     cfg_hold_cycles,
  input  logic                    cfg_skip_zero,
  output logic [P_NUM_INPUTS-1:0] wl_bitmap_out,
  output logic                    wl_valid_pulse_out,
  output logic [P_GROUP_W-1:0]    wl_data,
  output logic [IDX_W-1:0]        wl_group_sel,
  output logic                    wl_latch,
  output logic                    wl_busy,
  output logic [CNT_W-1:0]        last_groups_sent
);

  localparam int PTR_W = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(P_FIFO_DEPTH + 1);

  if ((P_NUM_INPUTS % P_GROUP_W) != 0) begin : g_bad_group_w
    $fatal(1, "P_NUM_INPUTS must be a multiple of P_GROUP_W");
  end
  if ((P_FIFO_DEPTH < 1) || ((P_FIFO_DEPTH & (P_FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "P_FIFO_DEPTH must be a power of two and at least 1");
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(P_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Frame FIFO
  logic [P_NUM_INPUTS-1:0] fifo_mem [P_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [OCC_W-1:0]        occ;
  logic                    fifo_full, fifo_empty, push, pop;
  logic [P_NUM_INPUTS-1:0] head;

  // Frame FSM registers
  wl_tdm_state_t           state_q, state_d;
  logic [P_NUM_INPUTS-1:0] wl_buf, buf_d;
  logic [IDX_W-1:0]        grp_idx, grp_d;
  logic [P_HOLD_W-1:0]     hold_cnt, hold_d;
  logic [P_HOLD_W-1:0]     hold_q, hcfg_d;
  logic                    skip_q, skip_d;
  logic [CNT_W-1:0]        sent_cnt, sent_d;
  logic [CNT_W-1:0]        last_d;

  // Group views and finder hookup
  logic [P_GROUP_W-1:0]    buf_groups [GROUPS];
  logic [GROUPS-1:0]       buf_nz, head_nz, fnd_mask;
  logic [IDX_W-1:0]        fnd_next, fnd_first;
  logic                    fnd_found, fnd_skip;

  // Ready depends on occupancy alone, so a same-cycle pop never opens the door early.
  assign fifo_full             = (occ == OCC_W'(P_FIFO_DEPTH));
  assign fifo_empty            = (occ == '0);
  assign frame_if.wl_ready_out = !fifo_full;
  assign push                  = frame_if.wl_valid_in && !fifo_full;
  assign head                  = fifo_mem[rd_ptr];

  for (genvar g = 0; g < GROUPS; g++) begin : g_split
    assign buf_groups[g] = wl_buf[g*P_GROUP_W +: P_GROUP_W];
    assign buf_nz[g]     = |wl_buf[g*P_GROUP_W +: P_GROUP_W];
    assign head_nz[g]    = |head[g*P_GROUP_W +: P_GROUP_W];
  end

  // In IDLE the finder looks at the FIFO head to choose the first group;
  // otherwise it looks at the latched frame to choose the next one.
  assign fnd_mask = (state_q == ST_IDLE) ? head_nz : buf_nz;
  assign fnd_skip = (state_q == ST_IDLE) ? cfg_skip_zero : skip_q;

  wl_group_next_finder #(.GROUPS(GROUPS)) u_finder (
    .nz_mask   (fnd_mask),
    .cur_idx   (grp_idx),
    .skip      (fnd_skip),
    .next_idx  (fnd_next),
    .found     (fnd_found),
    .first_idx (fnd_first)
  );

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= frame_if.wl_bitmap_in;
  end

  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      wl_buf           <= '0;
      grp_idx          <= '0;
      hold_cnt         <= '0;
      hold_q           <= '0;
      skip_q           <= 1'b0;
      sent_cnt         <= '0;
      last_groups_sent <= '0;
    end else begin
      state_q          <= state_d;
      wl_buf           <= buf_d;
      grp_idx          <= grp_d;
      hold_cnt         <= hold_d;
      hold_q           <= hcfg_d;
      skip_q           <= skip_d;
      sent_cnt         <= sent_d;
      last_groups_sent <= last_d;
    end
  end

  // Frame FSM next-state: pop and latch config in IDLE, walk groups in SEND, report in DONE
  always_comb begin
    state_d = state_q;
    buf_d   = wl_buf;
    grp_d   = grp_idx;
    hold_d  = hold_cnt;
    hcfg_d  = hold_q;
    skip_d  = skip_q;
    sent_d  = sent_cnt;
    last_d  = last_groups_sent;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          buf_d   = head;
          hcfg_d  = cfg_hold_cycles;
          skip_d  = cfg_skip_zero;
          grp_d   = fnd_first;
          hold_d  = '0;
          sent_d  = '0;
          state_d = (cfg_skip_zero && (head_nz == '0)) ? ST_DONE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (hold_cnt == hold_q) begin
          hold_d = '0;
          if (sent_cnt != CNT_W'(GROUPS)) sent_d = sent_cnt + 1'b1;
          if (fnd_found) grp_d   = fnd_next;
          else           state_d = ST_DONE;
        end else begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        last_d  = sent_cnt;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wl_latch           = (state_q == ST_SEND);
  assign wl_busy            = (state_q != ST_IDLE);
  assign wl_valid_pulse_out = (state_q == ST_DONE);
  assign wl_data            = buf_groups[grp_idx];
  assign wl_group_sel       = grp_idx;
  assign wl_bitmap_out      = wl_buf;

endmodule

// File: tb/tb_wl_tdm_serializer.sv
// tb/tb_wl_tdm_serializer.sv - directed self-checking bench for wl_tdm_serializer
module tb_wl_tdm_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_hold_cycles;
  logic        cfg_skip_zero;
  logic [63:0] wl_bitmap_out;
  logic        wl_valid_pulse_out;
  logic [7:0]  wl_data;
  logic [2:0]  wl_group_sel;
  logic        wl_latch;
  logic        wl_busy;
  logic [3:0]  last_groups_sent;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] lat_q [$];
  int          pls_q [$];
  logic [63:0] pbm_q [$];
  int          lgs_q [$];
  bit          pls_prev = 1'b0;

  always #5 clk = ~clk;

  wl_tdm_serializer_if #(.P_NUM_INPUTS(64)) frame_if ();

  wl_tdm_serializer #(
    .P_NUM_INPUTS (64),
    .P_GROUP_W    (8),
    .P_HOLD_W     (4),
    .P_FIFO_DEPTH (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .frame_if           (frame_if),
    .cfg_hold_cycles    (cfg_hold_cycles),
    .cfg_skip_zero      (cfg_skip_zero),
    .wl_bitmap_out      (wl_bitmap_out),
    .wl_valid_pulse_out (wl_valid_pulse_out),
    .wl_data            (wl_data),
    .wl_group_sel       (wl_group_sel),
    .wl_latch           (wl_latch),
    .wl_busy            (wl_busy),
    .last_groups_sent   (last_groups_sent)
  );

  // Cycle counter, advanced on every active edge
  always @(posedge clk) cyc <= cyc + 1;

  // Log latch beats, completion pulses and the group count that follows each pulse
  always @(negedge clk) begin
    if (rst) begin
      pls_prev <= 1'b0;
    end else begin
      if (wl_latch) lat_q.push_back({cyc[15:0], 5'b0, wl_group_sel, wl_data});
      if (wl_valid_pulse_out) begin
        pls_q.push_back(cyc);
        pbm_q.push_back(wl_bitmap_out);
      end
      if (pls_prev) lgs_q.push_back(int'(last_groups_sent));
      pls_prev <= wl_valid_pulse_out;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    lat_q.delete();
    pls_q.delete();
    pbm_q.delete();
    lgs_q.delete();
  endtask

  // Offer a frame at a negedge; returns the cycle stamp seen just after the accepting edge
  task automatic push(input string tag, input logic [63:0] bm, output int acc);
    int waits;
    waits = 0;
    frame_if.wl_bitmap_in = bm;
    frame_if.wl_valid_in  = 1'b1;
    while (!frame_if.wl_ready_out && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) check({tag, "_push_timeout"}, 64'(waits), 0);
    @(negedge clk);
    acc = cyc;
    frame_if.wl_valid_in = 1'b0;
  endtask

  task automatic wait_pulses(input string tag, input int n);
    int k;
    k = 0;
    while (pls_q.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_pulse_count"}, 64'(pls_q.size()), 64'(n));
  endtask

  // Expected sequence: each sent group held h+1 cycles from 'start', pulse right after
  task automatic check_frame(input string tag, input logic [63:0] bm, input int h,
                             input bit skip, input int start, output int next_start);
    int          t;
    int          n;
    logic [7:0]  g;
    logic [31:0] ent;
    int          got;
    t = start;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      g = bm[i*8 +: 8];
      if (!(skip && g == 8'h00)) begin
        n++;
        for (int j = 0; j <= h; j++) begin
          ent = (lat_q.size() > 0) ? lat_q.pop_front() : 32'hffff_ffff;
          check($sformatf("%s_latch_g%0d_h%0d", tag, i, j), 64'(ent), 64'({t[15:0], 5'b0, i[2:0], g}));
          t++;
        end
      end
    end
    got = (pls_q.size() > 0) ? pls_q.pop_front() : -1;
    check({tag, "_pulse_cycle"}, 64'(got), 64'(t));
    check({tag, "_bitmap_out"}, (pbm_q.size() > 0) ? pbm_q.pop_front() : 64'hdead, bm);
    got = (lgs_q.size() > 0) ? lgs_q.pop_front() : -1;
    check({tag, "_groups_sent"}, 64'(got), 64'(n));
    next_start = t + 2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] f1, f3, f5;
    int acc, acc2, acc3, acc4, nx, acc_b;

    f1 = 64'h8877_6655_4433_2211;
    f3 = 64'h0000_00FF_0000_0001;
    f5 = 64'h0000_AA00_0000_5500;

    rst                   = 1'b1;
    frame_if.wl_bitmap_in = '0;
    frame_if.wl_valid_in  = 1'b0;
    cfg_hold_cycles       = 4'd0;
    cfg_skip_zero         = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_ready", 64'(frame_if.wl_ready_out), 1);
    check("rst_latch", 64'(wl_latch), 0);
    check("rst_pulse", 64'(wl_valid_pulse_out), 0);
    check("rst_busy", 64'(wl_busy), 0);
    check("rst_data", 64'(wl_data), 0);
    check("rst_sel", 64'(wl_group_sel), 0);
    check("rst_last", 64'(last_groups_sent), 0);
    check("rst_bitmap", wl_bitmap_out, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic timing, H=0, no skip
    clear_logs();
    push("t1", f1, acc);
    check("t1_busy_pop_cycle", 64'(wl_busy), 0);
    wait_pulses("t1", 1);
    check("t1_pulse_rel", 64'(pls_q[0] - acc + 1), 64'd10);
    check_frame("t1", f1, 0, 1'b0, acc + 1, nx);
    check("t1_extra_latch", 64'(lat_q.size()), 0);

    // Hold of 2 extra cycles per group
    cfg_hold_cycles = 4'd2;
    clear_logs();
    push("t2", f1, acc);
    wait_pulses("t2", 1);
    check("t2_pulse_rel", 64'(pls_q[0] - acc + 1), 64'd26);
    check_frame("t2", f1, 2, 1'b0, acc + 1, nx);
    check("t2_extra_latch", 64'(lat_q.size()), 0);

    // Sparse mode
    cfg_hold_cycles = 4'd0;
    cfg_skip_zero   = 1'b1;
    clear_logs();
    push("t3", f3, acc);
    wait_pulses("t3", 1);
    check("t3_pulse_rel", 64'(pls_q[0] - acc + 1), 64'd4);
    check_frame("t3", f3, 0, 1'b1, acc + 1, nx);
    clear_logs();
    push("t3z", 64'h0, acc);
    wait_pulses("t3z", 1);
    check("t3z_pulse_rel", 64'(pls_q[0] - acc + 1), 64'd2);
    check_frame("t3z", 64'h0, 0, 1'b1, acc + 1, nx);
    check("t3z_no_latch", 64'(lat_q.size()), 0);

    // Backpressure with depth 2
    cfg_skip_zero = 1'b0;
    clear_logs();
    push("t4a", 64'h0101_0101_0101_0101, acc);
    push("t4b", 64'h0202_0202_0202_0202, acc2);
    push("t4c", 64'h0303_0303_0303_0303, acc3);
    check("t4_acc2", 64'(acc2 - acc), 1);
    check("t4_acc3", 64'(acc3 - acc), 2);
    check("t4_ready_full", 64'(frame_if.wl_ready_out), 0);
    push("t4d", 64'h0404_0404_0404_0404, acc4);
    check("t4_acc4", 64'(acc4 - acc), 12);
    wait_pulses("t4", 4);
    check_frame("t4a", 64'h0101_0101_0101_0101, 0, 1'b0, acc + 1, nx);
    check_frame("t4b", 64'h0202_0202_0202_0202, 0, 1'b0, nx, nx);
    check_frame("t4c", 64'h0303_0303_0303_0303, 0, 1'b0, nx, nx);
    check_frame("t4d", 64'h0404_0404_0404_0404, 0, 1'b0, nx, nx);
    check("t4_extra_latch", 64'(lat_q.size()), 0);

    // Config change mid-frame
    cfg_hold_cycles = 4'd1;
    cfg_skip_zero   = 1'b0;
    clear_logs();
    push("t5a", f5, acc);
    repeat (3) @(negedge clk);
    cfg_hold_cycles = 4'd0;
    cfg_skip_zero   = 1'b1;
    push("t5b", f5, acc_b);
    wait_pulses("t5", 2);
    check_frame("t5a", f5, 1, 1'b0, acc + 1, nx);
    check_frame("t5b", f5, 0, 1'b1, nx, nx);
    check("t5_extra_latch", 64'(lat_q.size()), 0);

    // Reset in the middle of a frame with another frame queued
    cfg_hold_cycles = 4'd0;
    cfg_skip_zero   = 1'b0;
    clear_logs();
    push("t6a", f1, acc);
    push("t6b", 64'h0505_0505_0505_0505, acc2);
    repeat (3) @(negedge clk);
    check("t6_sel_before_rst", 64'(wl_group_sel), 3);
    check("t6_latch_before_rst", 64'(wl_latch), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_latch", 64'(wl_latch), 0);
    check("t6_busy", 64'(wl_busy), 0);
    check("t6_ready", 64'(frame_if.wl_ready_out), 1);
    check("t6_pulse", 64'(wl_valid_pulse_out), 0);
    check("t6_last", 64'(last_groups_sent), 0);
    clear_logs();
    repeat (20) @(negedge clk);
    check("t6_no_pulse", 64'(pls_q.size()), 0);
    check("t6_no_latch", 64'(lat_q.size()), 0);
    push("t6c", f3, acc);
    wait_pulses("t6c", 1);
    check("t6c_pulse_rel", 64'(pls_q[0] - acc + 1), 64'd10);
    check_frame("t6c", f3, 0, 1'b0, acc + 1, nx);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
